// File: rtl/frame_ring_pkg.sv
// Shared types and helpers for the frame-ring buffer manager.
//
// Contents:
//   buf_state_e  - ownership state of one VRAM frame buffer
//   ring_state_e - renderer-side handshake FSM states
//   MAX_BUF      - largest supported ring size
//   lowestSetIdx - index of the least significant set bit in a MAX_BUF-wide mask
//
// Optional feature macro (used by frame_ring_ctrl): FRAME_RING_STATS_EN
package frame_ring_pkg;

  localparam int MAX_BUF   = 4;
  localparam int MAX_IDX_W = 2;

  typedef enum logic [1:0] {
    BUF_FREE    = 2'd0,
    BUF_WRITING = 2'd1,
    BUF_READY   = 2'd2,
    BUF_DISPLAY = 2'd3
  } buf_state_e;

  typedef enum logic [1:0] {
    RING_IDLE     = 2'd0,
    RING_WAIT_BUF = 2'd1,
    RING_RENDER   = 2'd2
  } ring_state_e;

  // Scan from the top down so the last hit is the lowest index.
  function automatic logic [MAX_IDX_W-1:0] lowestSetIdx(input logic [MAX_BUF-1:0] mask);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_BUF - 1; i >= 0; i--) begin
      if (mask[i]) idx = MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/frame_ring_pick.sv
// Combinational priority finder over a mask of candidate buffers.
//
// Ports:
//   mask  in  NUM_BUF  one bit per buffer, set when the buffer is a candidate
//   found out 1        at least one mask bit is set
//   idx   out IDX_W    index of the lowest set bit (0 when none set)
module frame_ring_pick
  import frame_ring_pkg::*;
#(
  parameter int NUM_BUF = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_BUF-1:0] mask,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_BUF-1:0] w_maskExt;

  // Widen to the package helper's fixed width; unused upper lanes stay clear.
  always_comb begin
    w_maskExt = '0;
    w_maskExt[NUM_BUF-1:0] = mask;
  end

  assign found = |mask;
  assign idx   = IDX_W'(lowestSetIdx(w_maskExt));

endmodule

// File: rtl/frame_ring_ctrl.sv
// Frame-ring manager for NUM_BUF (2..4) VRAM frame buffers.
// Tracks per-buffer ownership (FREE/WRITING/READY/DISPLAY), hands free
// buffers to the renderer, promotes the newest completed frame to the
// display on each vsync_tick, and steers registered renderer writes to
// exactly one VRAM write port.
//
// Ports:
//   clk, rst                    system clock, synchronous active-high reset
//   vsync_tick                  1-cycle frame boundary pulse (clk domain)
//   render_start / render_done  renderer request / completion handshake
//   wr_en, wr_addr, wr_data     renderer pixel write
//   render_busy, render_stall   renderer holds a buffer / waits for one
//   back_idx, front_idx         buffer being written / displayed
//   swap_tick                   1-cycle pulse with each front_idx change
//   web, wr_addr_o, wr_data_o   registered one-hot enables + broadcast bus
//   drop_cnt, repeat_cnt        only with FRAME_RING_STATS_EN defined
//
// Optional macro: FRAME_RING_STATS_EN adds saturating drop/repeat counters.
module frame_ring_ctrl
  import frame_ring_pkg::*;
#(
  parameter int NUM_BUF = 3,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16,
  localparam int IDX_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vsync_tick,
  input  logic              render_start,
  input  logic              render_done,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              render_busy,
  output logic              render_stall,
  output logic [IDX_W-1:0]  back_idx,
  output logic [IDX_W-1:0]  front_idx,
  output logic              swap_tick,
  output logic [NUM_BUF-1:0] web,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o
`ifdef FRAME_RING_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       repeat_cnt
`endif
);

  buf_state_e         r_bufState [NUM_BUF];
  buf_state_e         w_bufStateNxt [NUM_BUF];
  ring_state_e        r_ringState, w_ringNxt;
  logic [IDX_W-1:0]   r_backIdx, w_backNxt;
  logic [IDX_W-1:0]   r_frontIdx, w_frontNxt;
  logic               r_swapTick, w_swapNxt;
  logic [NUM_BUF-1:0] r_web, w_webNxt;
  logic [ADDR_W-1:0]  r_wrAddr;
  logic [DATA_W-1:0]  r_wrData;

  logic [NUM_BUF-1:0] w_freeMask;
  logic [MAX_BUF-1:0] w_readyMaskExt;
  logic               w_freeFound, w_readyFound;
  logic [IDX_W-1:0]   w_freeIdx, w_readyIdx;
  logic               w_grant, w_doneFire, w_renderBusy;

  // Masks come from registered state only, so a buffer released this cycle
  // cannot be granted until the following cycle.
  always_comb begin
    w_freeMask     = '0;
    w_readyMaskExt = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      w_freeMask[i]     = (r_bufState[i] == BUF_FREE);
      w_readyMaskExt[i] = (r_bufState[i] == BUF_READY);
    end
  end

  frame_ring_pick #(
    .NUM_BUF (NUM_BUF),
    .IDX_W   (IDX_W)
  ) u_pick (
    .mask  (w_freeMask),
    .found (w_freeFound),
    .idx   (w_freeIdx)
  );

  assign w_readyFound = |w_readyMaskExt;
  assign w_readyIdx   = IDX_W'(lowestSetIdx(w_readyMaskExt));
  assign w_renderBusy = (r_ringState == RING_RENDER);
  assign w_doneFire   = w_renderBusy & render_done;

  // Renderer FSM plus buffer ownership transitions. A grant only happens
  // outside RENDER and a completion only inside it, so they never collide;
  // a grant also only touches a FREE buffer, never the swap participants.
  always_comb begin
    w_bufStateNxt = r_bufState;
    w_ringNxt     = r_ringState;
    w_backNxt     = r_backIdx;
    w_frontNxt    = r_frontIdx;
    w_swapNxt     = 1'b0;
    w_grant       = 1'b0;

    unique case (r_ringState)
      RING_IDLE: begin
        if (render_start) begin
          if (w_freeFound) w_grant = 1'b1;
          else             w_ringNxt = RING_WAIT_BUF;
        end
      end
      RING_WAIT_BUF: begin
        if (w_freeFound) w_grant = 1'b1;
      end
      RING_RENDER: begin
        if (render_done) w_ringNxt = RING_IDLE;
      end
      default: w_ringNxt = RING_IDLE;
    endcase

    if (w_grant) begin
      w_bufStateNxt[w_freeIdx] = BUF_WRITING;
      w_backNxt                = w_freeIdx;
      w_ringNxt                = RING_RENDER;
    end

    if (w_doneFire) begin
      // An older completed frame that was never shown is dropped.
      if (w_readyFound) w_bufStateNxt[w_readyIdx] = BUF_FREE;
      if (vsync_tick) begin
        // Completion on the frame boundary skips READY and is shown at once.
        w_bufStateNxt[r_frontIdx] = BUF_FREE;
        w_bufStateNxt[r_backIdx]  = BUF_DISPLAY;
        w_frontNxt                = r_backIdx;
        w_swapNxt                 = 1'b1;
      end else begin
        w_bufStateNxt[r_backIdx] = BUF_READY;
      end
    end else if (vsync_tick && w_readyFound) begin
      w_bufStateNxt[r_frontIdx] = BUF_FREE;
      w_bufStateNxt[w_readyIdx] = BUF_DISPLAY;
      w_frontNxt                = w_readyIdx;
      w_swapNxt                 = 1'b1;
    end
  end

  // A write coinciding with a done+vsync bypass would land in the buffer
  // that becomes front on the same edge, so that one write is suppressed
  // to keep the displayed buffer untouched.
  always_comb begin
    w_webNxt = '0;
    if (wr_en && w_renderBusy && !(w_doneFire && vsync_tick)) begin
      w_webNxt[r_backIdx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BUF; i++) begin
        r_bufState[i] <= (i == 0) ? BUF_DISPLAY : BUF_FREE;
      end
      r_ringState <= RING_IDLE;
      r_backIdx   <= '0;
      r_frontIdx  <= '0;
      r_swapTick  <= 1'b0;
      r_web       <= '0;
      r_wrAddr    <= '0;
      r_wrData    <= '0;
    end else begin
      r_bufState  <= w_bufStateNxt;
      r_ringState <= w_ringNxt;
      r_backIdx   <= w_backNxt;
      r_frontIdx  <= w_frontNxt;
      r_swapTick  <= w_swapNxt;
      r_web       <= w_webNxt;
      r_wrAddr    <= wr_addr;
      r_wrData    <= wr_data;
    end
  end

`ifdef FRAME_RING_STATS_EN
  logic [15:0] r_dropCnt, r_repeatCnt;
  logic        w_dropEvt, w_repeatEvt;

  assign w_dropEvt   = w_doneFire & w_readyFound;
  assign w_repeatEvt = vsync_tick & ~w_readyFound & ~w_doneFire;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dropCnt   <= '0;
      r_repeatCnt <= '0;
    end else begin
      if (w_dropEvt && (r_dropCnt != 16'hFFFF))     r_dropCnt   <= r_dropCnt + 16'd1;
      if (w_repeatEvt && (r_repeatCnt != 16'hFFFF)) r_repeatCnt <= r_repeatCnt + 16'd1;
    end
  end

  assign drop_cnt   = r_dropCnt;
  assign repeat_cnt = r_repeatCnt;
`endif

  assign render_busy  = w_renderBusy;
  assign render_stall = (r_ringState == RING_WAIT_BUF);
  assign back_idx     = r_backIdx;
  assign front_idx    = r_frontIdx;
  assign swap_tick    = r_swapTick;
  assign web          = r_web;
  assign wr_addr_o    = r_wrAddr;
  assign wr_data_o    = r_wrData;

endmodule
